gpu_shader_dispatch_arbiter: RTL and testbench

- Shares one gpu shader core (1-entry pipeline, ADD/SUB/MUL/MAC, scalar or vector) among NUM_REQ requesters, for example warp slots.
- Picks one requester round-robin, forwards its packed instruction+operand payload to the core, then routes the single result back to that requester.
- Sits between the warp front-ends and the core. The integration wrapper splits the core payload onto the core's instruction/data interfaces.
- Adds a per-operation watchdog and a runtime enable/mask.

---
 rtl/gpu_shader_pkg.sv | 78 +++++++
 rtl/gpu_rr_picker.sv | 42 ++++
 rtl/gpu_shader_dispatch_arbiter.sv | 158 +++++++++++++++
 tb/tb_gpu_shader_dispatch_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_shader_pkg.sv
// Shared definitions for the gpu shader dispatch path.
//   opcode_e     : shader core operation codes
//   arb_state_e  : dispatch arbiter FSM states
//   payload_w()  : packed instruction+operand payload width
//   res_w()      : packed result width (result_s, result_v)
//   pl_*_lsb()   : payload field LSB offsets; field order MSB..LSB is
//                  opcode, is_vector, a_s, b_s, c_s, a_v, b_v, c_v
//   DEF_*        : widths/offsets for the default configuration
package gpu_shader_pkg;

  typedef enum logic [3:0] {
    ADD = 4'd0,
    SUB = 4'd1,
    MUL = 4'd2,
    MAC = 4'd3
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  function automatic int payload_w(input int width, input int lanes, input int opcode_w);
    return opcode_w + 1 + 3 * width + 3 * width * lanes;
  endfunction

  function automatic int res_w(input int width, input int lanes);
    return width + width * lanes;
  endfunction

  function automatic int pl_c_v_lsb(input int width, input int lanes);
    return 0 * width * lanes;
  endfunction

  function automatic int pl_b_v_lsb(input int width, input int lanes);
    return 1 * width * lanes;
  endfunction

  function automatic int pl_a_v_lsb(input int width, input int lanes);
    return 2 * width * lanes;
  endfunction

  function automatic int pl_c_s_lsb(input int width, input int lanes);
    return 3 * width * lanes;
  endfunction

  function automatic int pl_b_s_lsb(input int width, input int lanes);
    return 3 * width * lanes + width;
  endfunction

  function automatic int pl_a_s_lsb(input int width, input int lanes);
    return 3 * width * lanes + 2 * width;
  endfunction

  function automatic int pl_is_vector_lsb(input int width, input int lanes);
    return 3 * width * lanes + 3 * width;
  endfunction

  function automatic int pl_opcode_lsb(input int width, input int lanes);
    return 3 * width * lanes + 3 * width + 1;
  endfunction

  localparam int DEF_WIDTH         = 32;
  localparam int DEF_LANES         = 4;
  localparam int DEF_OPCODE_W      = 4;
  localparam int DEF_PAYLOAD_W     = payload_w(DEF_WIDTH, DEF_LANES, DEF_OPCODE_W);
  localparam int DEF_RES_W         = res_w(DEF_WIDTH, DEF_LANES);
  localparam int DEF_OPCODE_LSB    = pl_opcode_lsb(DEF_WIDTH, DEF_LANES);
  localparam int DEF_IS_VECTOR_LSB = pl_is_vector_lsb(DEF_WIDTH, DEF_LANES);
  localparam int DEF_A_S_LSB       = pl_a_s_lsb(DEF_WIDTH, DEF_LANES);
  localparam int DEF_B_S_LSB       = pl_b_s_lsb(DEF_WIDTH, DEF_LANES);
  localparam int DEF_C_S_LSB       = pl_c_s_lsb(DEF_WIDTH, DEF_LANES);
  localparam int DEF_A_V_LSB       = pl_a_v_lsb(DEF_WIDTH, DEF_LANES);
  localparam int DEF_B_V_LSB       = pl_b_v_lsb(DEF_WIDTH, DEF_LANES);
  localparam int DEF_C_V_LSB       = pl_c_v_lsb(DEF_WIDTH, DEF_LANES);

endpackage

// File: rtl/gpu_rr_picker.sv
// Combinational round-robin find-first.
//   elig   in  N      eligibility vector
//   rr_ptr in  IDX_W  highest-priority index for this search
//   found  out 1      at least one eligible bit
//   idx    out IDX_W  first eligible index at or above rr_ptr, wrapping
//                     from N-1 back to 0 (0 when nothing is found)
module gpu_rr_picker #(
  parameter int N = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     elig,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // cand[k] is the requester searched k-th, i.e. (rr_ptr + k) mod N.
  // rr_ptr < N and k < N, so one conditional subtract is enough.
  logic [IDX_W-1:0] cand [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, rr_ptr} + (IDX_W + 1)'(gi);
      assign cand[gi] = (sum >= (IDX_W + 1)'(N)) ? IDX_W'(sum - (IDX_W + 1)'(N))
                                                 : sum[IDX_W-1:0];
    end
  endgenerate

  // Walk from the farthest candidate to the nearest, so the nearest eligible one wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/gpu_shader_dispatch_arbiter.sv
// Round-robin arbiter sharing one single-entry shader core among NUM_REQ
// requesters. One operation at a time: IDLE (pick) -> ISSUE (forward the
// owner's payload) -> WAIT (route the core result back to the owner).
//   clk, rst            clock, asynchronous active-high reset
//   cfg_enable          global grant enable, sampled only in IDLE
//   cfg_req_mask        per-requester eligibility, sampled only in IDLE
//   req_valid/ready     per-requester request handshake
//   req_payload         requester i occupies slice i (PAYLOAD_W bits each)
//   rsp_valid/ready     per-requester result handshake
//   rsp_result          shared result bus, nonzero only in WAIT
//   core_valid/ready    core issue handshake
//   core_payload        owner's payload, nonzero only in ISSUE
//   core_res_valid/ready/core_res  core result handshake
//   busy                FSM not in IDLE
//   owner               current / last grant index
//   err_timeout         sticky watchdog flag
module gpu_shader_dispatch_arbiter
  import gpu_shader_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 32,
  parameter int LANES    = 4,
  parameter int OPCODE_W = 4,
  parameter int TIMEOUT  = 64,
  localparam int PAYLOAD_W = payload_w(WIDTH, LANES, OPCODE_W),
  localparam int RES_W     = res_w(WIDTH, LANES),
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_enable,
  input  logic [NUM_REQ-1:0]           cfg_req_mask,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*PAYLOAD_W-1:0] req_payload,
  output logic [NUM_REQ-1:0]           rsp_valid,
  input  logic [NUM_REQ-1:0]           rsp_ready,
  output logic [RES_W-1:0]             rsp_result,
  output logic                         core_valid,
  input  logic                         core_ready,
  output logic [PAYLOAD_W-1:0]         core_payload,
  input  logic                         core_res_valid,
  output logic                         core_res_ready,
  input  logic [RES_W-1:0]             core_res,
  output logic                         busy,
  output logic [IDX_W-1:0]             owner,
  output logic                         err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  arb_state_e       state;
  logic [IDX_W-1:0] owner_reg;
  logic [IDX_W-1:0] rr_ptr_reg;
  logic [WD_W-1:0]  wdog_reg;
  logic             err_reg;

  logic [NUM_REQ-1:0] elig;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [PAYLOAD_W-1:0] payload_arr [NUM_REQ];

  logic owner_req_valid;
  logic owner_rsp_ready;
  logic res_done;

  assign elig = req_valid & cfg_req_mask & {NUM_REQ{cfg_enable}};

  gpu_rr_picker #(.N(NUM_REQ)) u_picker (
    .elig   (elig),
    .rr_ptr (rr_ptr_reg),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign payload_arr[gi] = req_payload[gi*PAYLOAD_W +: PAYLOAD_W];
    end
  endgenerate

  assign owner_req_valid = req_valid[owner_reg];
  assign owner_rsp_ready = rsp_ready[owner_reg];
  assign res_done        = core_res_valid & owner_rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner_reg  <= '0;
      rr_ptr_reg <= '0;
      wdog_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            owner_reg <= pick_idx;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // A requester withdrawing before acceptance aborts without advancing rr_ptr.
          if (!owner_req_valid) begin
            state <= IDLE;
          end else if (core_ready) begin
            state    <= WAIT;
            wdog_reg <= '0;
          end
        end
        WAIT: begin
          if (res_done) begin
            rr_ptr_reg <= (owner_reg == LAST_IDX) ? '0 : owner_reg + 1'b1;
            state      <= IDLE;
          end else begin
            // wdog counts completed WAIT cycles; the flag latches on the
            // same edge the count reaches TIMEOUT. The op itself is not released.
            if (wdog_reg != WD_MAX) begin
              wdog_reg <= wdog_reg + 1'b1;
            end
            if (wdog_reg == WD_MAX - 1'b1) begin
              err_reg <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready      = '0;
    rsp_valid      = '0;
    core_valid     = 1'b0;
    core_payload   = '0;
    core_res_ready = 1'b0;
    rsp_result     = '0;
    case (state)
      ISSUE: begin
        core_valid           = owner_req_valid;
        core_payload         = payload_arr[owner_reg];
        req_ready[owner_reg] = core_ready;
      end
      WAIT: begin
        rsp_valid[owner_reg] = core_res_valid;
        rsp_result           = core_res;
        core_res_ready       = owner_rsp_ready;
      end
      default: ;
    endcase
  end

  assign busy        = (state != IDLE);
  assign owner       = owner_reg;
  assign err_timeout = err_reg;

endmodule

// File: tb/tb_gpu_shader_dispatch_arbiter.sv
// Directed self-checking bench for gpu_shader_dispatch_arbiter (default
// parameters: 4 requesters, 32-bit, 4 lanes, TIMEOUT 64). The bench plays the
// core by driving core_ready / core_res_valid / core_res by hand.
module tb_gpu_shader_dispatch_arbiter;
  import gpu_shader_pkg::*;

  localparam int NR = 4;
  localparam int PW = payload_w(32, 4, 4);
  localparam int RW = res_w(32, 4);

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_enable;
  logic [NR-1:0]     cfg_req_mask;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*PW-1:0]  req_payload;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [RW-1:0]     rsp_result;
  logic              core_valid;
  logic              core_ready;
  logic [PW-1:0]     core_payload;
  logic              core_res_valid;
  logic              core_res_ready;
  logic [RW-1:0]     core_res;
  logic              busy;
  logic [1:0]        owner;
  logic              err_timeout;

  logic [PW-1:0] pl [NR];
  int checks = 0;
  int errors = 0;

  gpu_shader_dispatch_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_enable     (cfg_enable),
    .cfg_req_mask   (cfg_req_mask),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_payload    (req_payload),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_result     (rsp_result),
    .core_valid     (core_valid),
    .core_ready     (core_ready),
    .core_payload   (core_payload),
    .core_res_valid (core_res_valid),
    .core_res_ready (core_res_ready),
    .core_res       (core_res),
    .busy           (busy),
    .owner          (owner),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "simulation time limit");
  end

  function automatic logic [PW-1:0] mk_pl(input logic [3:0] op, input logic isv,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
    return {op, isv, a, b, c, {4{a}}, {4{b}}, {4{c}}};
  endfunction

  function automatic logic [RW-1:0] mk_res(input logic [31:0] v);
    return {v, {4{v}}};
  endfunction

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_idle_zero(input string tag, input logic exp_err);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_owner"}, owner, 0);
    chk({tag, "_core_valid"}, core_valid, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_core_res_ready"}, core_res_ready, 0);
    chk({tag, "_core_payload"}, core_payload, 0);
    chk({tag, "_rsp_result"}, rsp_result, 0);
    chk({tag, "_err"}, err_timeout, exp_err);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    chk_idle_zero("reset", 1'b0);
    rst = 1'b0;
  endtask

  // From IDLE with requests pending and core_ready=1, rsp_ready=all:
  // grant -> ISSUE -> WAIT -> result on the 2nd WAIT cycle -> IDLE.
  task automatic do_op(input int exp_owner);
    logic [3:0] oh;
    oh = 4'b0001 << exp_owner;
    tick();
    chk("op_owner", owner, exp_owner);
    chk("op_busy", busy, 1);
    chk("op_core_valid", core_valid, 1);
    chk("op_req_ready", req_ready, oh);
    chk("op_core_payload", core_payload, pl[exp_owner]);
    $display("grant issued to requester %0d", owner);
    tick();
    chk("op_wait_core_valid", core_valid, 0);
    chk("op_wait_req_ready", req_ready, 0);
    chk("op_wait_rsp_valid", rsp_valid, 0);
    tick();
    core_res_valid = 1'b1;
    core_res = mk_res(32'd100 + 32'(exp_owner));
    settle();
    chk("op_rsp_valid", rsp_valid, oh);
    chk("op_rsp_result", rsp_result, mk_res(32'd100 + 32'(exp_owner)));
    chk("op_core_res_ready", core_res_ready, 1);
    tick();
    core_res_valid = 1'b0;
    core_res = '0;
    chk("op_done_busy", busy, 0);
    chk("op_done_rsp_result", rsp_result, 0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_enable = 1'b1;
    cfg_req_mask = 4'b1111;
    req_valid = '0;
    rsp_ready = 4'b1111;
    core_ready = 1'b1;
    core_res_valid = 1'b0;
    core_res = '0;
    pl[0] = mk_pl(ADD, 1'b0, 32'd5, 32'd7, 32'd0);
    pl[1] = mk_pl(SUB, 1'b1, 32'h11, 32'h22, 32'h33);
    pl[2] = mk_pl(MUL, 1'b0, 32'hA5A5_0001, 32'h3, 32'h0);
    pl[3] = mk_pl(MAC, 1'b1, 32'hDEAD_BEEF, 32'h2, 32'h7);
    req_payload = {pl[3], pl[2], pl[1], pl[0]};
    tick();
    tick();
    do_reset();

    // Single requester 0, ADD 5+7.
    req_valid = 4'b0001;
    settle();
    chk("t1_idle_core_valid", core_valid, 0);
    chk("t1_idle_req_ready", req_ready, 0);
    tick();
    chk("t1_busy", busy, 1);
    chk("t1_core_valid", core_valid, 1);
    chk("t1_req_ready", req_ready, 4'b0001);
    chk("t1_opcode", core_payload[DEF_OPCODE_LSB +: 4], ADD);
    chk("t1_a_s", core_payload[DEF_A_S_LSB +: 32], 5);
    chk("t1_b_s", core_payload[DEF_B_S_LSB +: 32], 7);
    tick();
    req_valid = 4'b0000;
    core_res_valid = 1'b1;
    core_res = {32'd12, 128'd0};
    settle();
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_result_s", rsp_result[RW-1 -: 32], 12);
    chk("t1_core_res_ready", core_res_ready, 1);
    chk("t1_busy_wait", busy, 1);
    $display("single op: result_s=%0d", rsp_result[RW-1 -: 32]);
    tick();
    core_res_valid = 1'b0;
    core_res = '0;
    chk("t1_busy_drop", busy, 0);
    chk("t1_rsp_valid_drop", rsp_valid, 0);

    // All four requesters continuously valid: 0,1,2,3,0.
    do_reset();
    req_valid = 4'b1111;
    do_op(0);
    do_op(1);
    do_op(2);
    do_op(3);
    do_op(0);

    // Mask 1010: 1,3,1,3 (rr_ptr is 1 after the last op of requester 0).
    cfg_req_mask = 4'b1010;
    do_op(1);
    do_op(3);
    do_op(1);
    do_op(3);

    // Enable dropped during WAIT: op completes, then no grant until re-enabled.
    tick();
    chk("en_owner", owner, 1);
    tick();
    cfg_enable = 1'b0;
    core_res_valid = 1'b1;
    core_res = mk_res(32'h55);
    settle();
    chk("en_rsp_valid", rsp_valid, 4'b0010);
    tick();
    core_res_valid = 1'b0;
    core_res = '0;
    chk("en_done_busy", busy, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("en_off_busy", busy, 0);
    end
    cfg_enable = 1'b1;
    tick();
    chk("en_on_busy", busy, 1);
    chk("en_on_owner", owner, 3);
    $display("grant after re-enable to requester %0d", owner);
    tick();
    core_res_valid = 1'b1;
    core_res = mk_res(32'h66);
    tick();
    core_res_valid = 1'b0;
    chk("en_final_busy", busy, 0);

    // Response backpressure for 10 cycles (rr_ptr=0, owner 0).
    cfg_req_mask = 4'b1111;
    tick();
    chk("bp_owner", owner, 0);
    tick();
    rsp_ready = 4'b0000;
    core_res_valid = 1'b1;
    core_res = mk_res(32'hCAFE_0001);
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("bp_rsp_valid", rsp_valid, 4'b0001);
      chk("bp_core_res_ready", core_res_ready, 0);
      chk("bp_rsp_result", rsp_result, mk_res(32'hCAFE_0001));
      chk("bp_busy", busy, 1);
      tick();
    end
    rsp_ready = 4'b1111;
    settle();
    chk("bp_release_ready", core_res_ready, 1);
    tick();
    core_res_valid = 1'b0;
    core_res = '0;
    chk("bp_done_busy", busy, 0);
    $display("backpressure op completed");

    // Watchdog: result withheld; flag latches after 64 full WAIT cycles.
    do_reset();
    tick();
    tick();
    chk("wd_in_wait", busy, 1);
    for (int k = 1; k <= 64; k++) begin
      chk("wd_err_low", err_timeout, 0);
      tick();
    end
    chk("wd_err_high", err_timeout, 1);
    chk("wd_still_wait", busy, 1);
    tick();
    tick();
    core_res_valid = 1'b1;
    core_res = mk_res(32'h77);
    tick();
    core_res_valid = 1'b0;
    core_res = '0;
    chk("wd_late_busy", busy, 0);
    chk("wd_err_sticky", err_timeout, 1);
    $display("watchdog flag=%0d after late result", err_timeout);
    do_reset();

    // Abort: requester 2 drops req_valid in ISSUE while core_ready=0.
    req_valid = 4'b0100;
    core_ready = 1'b0;
    tick();
    chk("ab_owner", owner, 2);
    chk("ab_core_valid", core_valid, 1);
    chk("ab_req_ready", req_ready, 0);
    req_valid = 4'b0000;
    settle();
    chk("ab_core_valid_drop", core_valid, 0);
    tick();
    chk("ab_idle", busy, 0);
    // rr_ptr still 0 -> picks 1 (would be 3 if it had advanced past 2).
    req_valid = 4'b1010;
    core_ready = 1'b1;
    tick();
    chk("ab_next_owner", owner, 1);
    $display("grant after abort to requester %0d", owner);
    tick();
    chk("rm_in_wait", busy, 1);

    // Reset mid-WAIT, then next grant restarts from requester 0.
    rst = 1'b1;
    settle();
    chk_idle_zero("rm", 1'b0);
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    tick();
    chk("rm_next_owner", owner, 0);
    chk("rm_next_busy", busy, 1);
    $display("grant after mid-op reset to requester %0d", owner);
    req_valid = 4'b0000;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
